// File: rtl/ddr_wr_cmd_sched.sv
// rtl/ddr_wr_cmd_sched.sv - write-side DDR command scheduler draining address/data FIFOs into the native write interface
module ddr_wr_cmd_sched #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 256,
    parameter int BEATS  = 2
) (
    input  logic                  ddr_clk,
    input  logic                  sys_rst,
    input  logic                  phy_init_done_i,
    output logic                  wr_addr_fifo_rd_en,
    input  logic [29:0]           wr_addr_fifo_data_out,
    input  logic                  wr_addr_fifo_valid,
    input  logic                  wr_addr_fifo_empty,
    output logic                  wr_ddr_fifo_rd_en,
    input  logic [DATA_W-1:0]     wr_ddr_fifo_data_out,
    input  logic                  wr_ddr_fifo_valid,
    input  logic [8:0]            wr_ddr_fifo_rd_count,
    output logic                  app_en,
    output logic [2:0]            app_cmd,
    output logic [ADDR_W-1:0]     app_addr,
    input  logic                  app_rdy,
    output logic                  app_wdf_wren,
    output logic [DATA_W-1:0]     app_wdf_data,
    output logic                  app_wdf_end,
    output logic [DATA_W/8-1:0]   app_wdf_mask,
    input  logic                  app_wdf_rdy,
    output logic                  busy_o,
    output logic                  wr_done_o,
    output logic [31:0]           wr_cnt_o,
    output logic                  err_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_POP  = 3'd1;
    localparam logic [2:0] S_CAP0 = 3'd2;
    localparam logic [2:0] S_CAP1 = 3'd3;
    localparam logic [2:0] S_WDF0 = 3'd4;
    localparam logic [2:0] S_WDF1 = 3'd5;
    localparam logic [2:0] S_CMD  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] beat0_q, beat0_d;
    logic [DATA_W-1:0] beat1_q, beat1_d;
    logic [31:0]       cnt_q,   cnt_d;
    logic              err_q,   err_d;
    logic              addr_rd_en;
    logic              data_rd_en;
    logic              start_ok;

    // Address bits above ADDR_W carry no meaning for the controller.
    logic unused_addr_hi;
    assign unused_addr_hi = ^wr_addr_fifo_data_out[29:ADDR_W];

    // Threshold on the data FIFO guarantees both beats exist before the address is popped.
    assign start_ok = phy_init_done_i && !wr_addr_fifo_empty
                      && (wr_ddr_fifo_rd_count >= 9'(BEATS));

    // Next-state and capture logic for the pop/capture/data/command sequence.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beat0_d    = beat0_q;
        beat1_d    = beat1_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        addr_rd_en = 1'b0;
        data_rd_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                addr_rd_en = 1'b1;
                data_rd_en = 1'b1;
                state_d    = S_CAP0;
            end
            S_CAP0: begin
                if (wr_addr_fifo_valid && wr_ddr_fifo_valid) begin
                    addr_d     = wr_addr_fifo_data_out[ADDR_W-1:0];
                    beat0_d    = wr_ddr_fifo_data_out;
                    data_rd_en = 1'b1;
                    state_d    = S_CAP1;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CAP1: begin
                if (wr_ddr_fifo_valid) begin
                    beat1_d = wr_ddr_fifo_data_out;
                    state_d = S_WDF0;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WDF0: begin
                if (app_wdf_rdy) begin
                    state_d = S_WDF1;
                end
            end
            S_WDF1: begin
                if (app_wdf_rdy) begin
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (app_rdy) begin
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any burst in flight.
    always_ff @(posedge ddr_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            beat0_q <= '0;
            beat1_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beat0_q <= beat0_d;
            beat1_q <= beat1_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign wr_addr_fifo_rd_en = addr_rd_en;
    assign wr_ddr_fifo_rd_en  = data_rd_en;

    assign app_wdf_wren = (state_q == S_WDF0) || (state_q == S_WDF1);
    assign app_wdf_end  = (state_q == S_WDF1);
    assign app_wdf_data = (state_q == S_WDF0) ? beat0_q :
                          (state_q == S_WDF1) ? beat1_q : '0;
    assign app_wdf_mask = '0;

    assign app_en   = (state_q == S_CMD);
    assign app_cmd  = 3'b000;
    assign app_addr = addr_q;

    assign busy_o    = (state_q != S_IDLE);
    assign wr_done_o = (state_q == S_CMD) && app_rdy;
    assign wr_cnt_o  = cnt_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_ddr_wr_cmd_sched.sv
// tb/tb_ddr_wr_cmd_sched.sv - scoreboard bench for ddr_wr_cmd_sched
module tb_ddr_wr_cmd_sched;

    logic         ddr_clk;
    logic         sys_rst;
    logic         phy_init_done_i;
    logic         wr_addr_fifo_rd_en;
    logic [29:0]  wr_addr_fifo_data_out;
    logic         wr_addr_fifo_valid;
    logic         wr_addr_fifo_empty;
    logic         wr_ddr_fifo_rd_en;
    logic [255:0] wr_ddr_fifo_data_out;
    logic         wr_ddr_fifo_valid;
    logic [8:0]   wr_ddr_fifo_rd_count;
    logic         app_en;
    logic [2:0]   app_cmd;
    logic [26:0]  app_addr;
    logic         app_rdy;
    logic         app_wdf_wren;
    logic [255:0] app_wdf_data;
    logic         app_wdf_end;
    logic [31:0]  app_wdf_mask;
    logic         app_wdf_rdy;
    logic         busy_o;
    logic         wr_done_o;
    logic [31:0]  wr_cnt_o;
    logic         err_o;

    ddr_wr_cmd_sched dut (
        .ddr_clk               (ddr_clk),
        .sys_rst               (sys_rst),
        .phy_init_done_i       (phy_init_done_i),
        .wr_addr_fifo_rd_en    (wr_addr_fifo_rd_en),
        .wr_addr_fifo_data_out (wr_addr_fifo_data_out),
        .wr_addr_fifo_valid    (wr_addr_fifo_valid),
        .wr_addr_fifo_empty    (wr_addr_fifo_empty),
        .wr_ddr_fifo_rd_en     (wr_ddr_fifo_rd_en),
        .wr_ddr_fifo_data_out  (wr_ddr_fifo_data_out),
        .wr_ddr_fifo_valid     (wr_ddr_fifo_valid),
        .wr_ddr_fifo_rd_count  (wr_ddr_fifo_rd_count),
        .app_en                (app_en),
        .app_cmd               (app_cmd),
        .app_addr              (app_addr),
        .app_rdy               (app_rdy),
        .app_wdf_wren          (app_wdf_wren),
        .app_wdf_data          (app_wdf_data),
        .app_wdf_end           (app_wdf_end),
        .app_wdf_mask          (app_wdf_mask),
        .app_wdf_rdy           (app_wdf_rdy),
        .busy_o                (busy_o),
        .wr_done_o             (wr_done_o),
        .wr_cnt_o              (wr_cnt_o),
        .err_o                 (err_o)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int rd_pulses = 0;
    int exp_cnt = 0;

    logic [29:0]  aq[$];
    logic [255:0] dq[$];
    logic [255:0] exp_data[$];
    logic         exp_last[$];
    logic [26:0]  exp_addr[$];

    bit       kill_beat1 = 0;
    bit       ovr_en = 0;
    logic [8:0] ovr_val = 9'd0;

    initial ddr_clk = 1'b0;
    always #5 ddr_clk = ~ddr_clk;

    task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // FIFO models: read data and valid appear one cycle after rd_en.
    always @(posedge ddr_clk) begin
        if (wr_addr_fifo_rd_en && aq.size() > 0) begin
            wr_addr_fifo_data_out <= aq.pop_front();
            wr_addr_fifo_valid    <= 1'b1;
        end else begin
            wr_addr_fifo_valid    <= 1'b0;
        end
        if (wr_ddr_fifo_rd_en && dq.size() > 0) begin
            wr_ddr_fifo_data_out <= dq.pop_front();
            wr_ddr_fifo_valid    <= !(kill_beat1 && !wr_addr_fifo_rd_en);
        end else begin
            wr_ddr_fifo_valid    <= 1'b0;
        end
    end

    always @(ddr_clk) begin
        #1;
        wr_addr_fifo_empty   = (aq.size() == 0);
        wr_ddr_fifo_rd_count = ovr_en ? ovr_val : 9'(dq.size());
    end

    // Monitor: compares every data/command presentation against the scoreboard.
    initial begin
        forever begin
            @(negedge ddr_clk);
            if (!sys_rst) begin
                exp_cnt = 0;
            end else begin
                if (wr_addr_fifo_rd_en || wr_ddr_fifo_rd_en) rd_pulses++;
                if (app_wdf_wren) begin
                    if (exp_data.size() == 0) begin
                        chk(0, "unexpected_wren", app_wdf_data, 256'd0);
                    end else if (app_wdf_rdy) begin
                        chk(app_wdf_data == exp_data[0] && app_wdf_end == exp_last[0] && app_wdf_mask == 32'd0,
                            "wdf_accept", {app_wdf_end, app_wdf_data[254:0]}, {exp_last[0], exp_data[0][254:0]});
                        void'(exp_data.pop_front());
                        void'(exp_last.pop_front());
                    end else begin
                        chk(app_wdf_data == exp_data[0] && app_wdf_end == exp_last[0],
                            "wdf_hold", {app_wdf_end, app_wdf_data[254:0]}, {exp_last[0], exp_data[0][254:0]});
                    end
                end
                if (app_en) begin
                    if (exp_addr.size() == 0) begin
                        chk(0, "unexpected_app_en", 256'(app_addr), 256'd0);
                    end else if (app_rdy) begin
                        chk(app_addr == exp_addr[0] && app_cmd == 3'b000, "cmd_accept",
                            256'({app_cmd, app_addr}), 256'({3'b000, exp_addr[0]}));
                        chk(wr_done_o == 1'b1 && wr_cnt_o == 32'(exp_cnt), "done_cnt",
                            256'({wr_done_o, wr_cnt_o}), 256'({1'b1, 32'(exp_cnt)}));
                        void'(exp_addr.pop_front());
                        exp_cnt++;
                    end else begin
                        chk(app_addr == exp_addr[0] && wr_done_o == 1'b0, "cmd_hold",
                            256'({wr_done_o, app_addr}), 256'({1'b0, exp_addr[0]}));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge ddr_clk);
        #2;
    endtask

    task automatic push(input logic [29:0] a, input logic [255:0] b0, input logic [255:0] b1,
                        input bit expect_out, input logic [26:0] ea);
        aq.push_back(a);
        dq.push_back(b0);
        dq.push_back(b1);
        if (expect_out) begin
            exp_data.push_back(b0); exp_last.push_back(1'b0);
            exp_data.push_back(b1); exp_last.push_back(1'b1);
            exp_addr.push_back(ea);
        end
    endtask

    task automatic wait_cnt(input logic [31:0] tgt, input int budget, input string nm);
        int n = 0;
        while (wr_cnt_o != tgt && n < budget) begin step(); n++; end
        chk(wr_cnt_o == tgt, nm, 256'(wr_cnt_o), 256'(tgt));
    endtask

    task automatic wait_wdf1(input int budget);
        int n = 0;
        while (!(app_wdf_wren && app_wdf_end) && n < budget) begin step(); n++; end
        chk(app_wdf_wren && app_wdf_end, "reach_wdf1", 256'(app_wdf_end), 256'd1);
    endtask

    task automatic wait_app_en(input int budget);
        int n = 0;
        while (!app_en && n < budget) begin step(); n++; end
        chk(app_en, "reach_cmd", 256'(app_en), 256'd1);
    endtask

    task automatic check_all_zero(input string nm);
        chk({wr_addr_fifo_rd_en, wr_ddr_fifo_rd_en, app_en, app_wdf_wren, app_wdf_end, busy_o, wr_done_o, err_o} == 8'd0
            && app_addr == 27'd0 && app_wdf_data == 256'd0 && wr_cnt_o == 32'd0 && app_cmd == 3'd0,
            nm, 256'({wr_addr_fifo_rd_en, wr_ddr_fifo_rd_en, app_en, app_wdf_wren, app_wdf_end, busy_o, wr_done_o, err_o, wr_cnt_o}),
            256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        sys_rst = 1'b0;
        phy_init_done_i = 1'b0;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        wr_addr_fifo_data_out = '0;
        wr_addr_fifo_valid = 1'b0;
        wr_ddr_fifo_data_out = '0;
        wr_ddr_fifo_valid = 1'b0;
        wr_addr_fifo_empty = 1'b1;
        wr_ddr_fifo_rd_count = 9'd0;
        repeat (3) step();
        check_all_zero("reset_state");
        sys_rst = 1'b1;

        // No calibration: queued entry must not be touched.
        push(30'h0000_1040, {8{32'hAAAA_0001}}, {8{32'hBBBB_0002}}, 1, 27'h000_1040);
        repeat (20) step();
        chk(rd_pulses == 0, "no_rd_without_phy", 256'(rd_pulses), 256'd0);
        chk(busy_o == 1'b0, "idle_without_phy", 256'(busy_o), 256'd0);

        // Single write with ready held high: command lands in cycle 7.
        phy_init_done_i = 1'b1;
        step();
        chk(wr_addr_fifo_rd_en && wr_ddr_fifo_rd_en, "pop_rd_en",
            256'({wr_addr_fifo_rd_en, wr_ddr_fifo_rd_en}), 256'(2'b11));
        step();
        chk(!wr_addr_fifo_rd_en && wr_ddr_fifo_rd_en, "cap0_rd_en",
            256'({wr_addr_fifo_rd_en, wr_ddr_fifo_rd_en}), 256'(2'b01));
        repeat (4) step();
        chk(app_en && app_addr == 27'h000_1040, "cmd_cycle7", 256'({app_en, app_addr}), 256'({1'b1, 27'h000_1040}));
        step();
        chk(wr_cnt_o == 32'd1 && !busy_o, "after_first", 256'({busy_o, wr_cnt_o}), 256'(32'd1));

        // Stalls in WDF1 and CMD; upper address bits are dropped.
        push(30'h3800_2000, {8{32'hCCCC_0003}}, {8{32'hDDDD_0004}}, 1, 27'h000_2000);
        wait_wdf1(20);
        app_wdf_rdy = 1'b0;
        repeat (5) step();
        app_wdf_rdy = 1'b1;
        wait_app_en(10);
        app_rdy = 1'b0;
        repeat (3) step();
        app_rdy = 1'b1;
        wait_cnt(32'd2, 10, "cnt_after_stall");

        // Data FIFO occupancy below threshold blocks the start.
        ovr_en = 1; ovr_val = 9'd1;
        push(30'h07FF_FFFF, {8{32'hEEEE_0005}}, {8{32'hFFFF_0006}}, 1, 27'h7FF_FFFF);
        snap = rd_pulses;
        repeat (10) step();
        chk(rd_pulses == snap && !busy_o, "hold_low_count", 256'(rd_pulses - snap), 256'd0);
        ovr_val = 9'd2;
        wait_cnt(32'd3, 30, "cnt_after_threshold");
        ovr_en = 0;

        // Missing second beat: sticky error, no write issued.
        kill_beat1 = 1;
        push(30'h0000_0123, {8{32'h1111_0007}}, {8{32'h2222_0008}}, 0, 27'd0);
        begin
            int n = 0;
            while (!err_o && n < 20) begin step(); n++; end
        end
        chk(err_o, "err_set", 256'(err_o), 256'd1);
        kill_beat1 = 0;
        repeat (5) step();
        chk(err_o && !busy_o && wr_cnt_o == 32'd3, "err_sticky",
            256'({err_o, busy_o, wr_cnt_o}), 256'({1'b1, 1'b0, 32'd3}));

        // Reset during a WDF1 stall aborts the burst; next entry runs cleanly.
        push(30'h0000_0200, {8{32'h3333_0009}}, {8{32'h4444_000A}}, 1, 27'h000_0200);
        push(30'h0000_0300, {8{32'h5555_000B}}, {8{32'h6666_000C}}, 1, 27'h000_0300);
        wait_wdf1(20);
        app_wdf_rdy = 1'b0;
        repeat (2) step();
        sys_rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        void'(exp_data.pop_front());
        void'(exp_last.pop_front());
        void'(exp_addr.pop_front());
        repeat (2) step();
        app_wdf_rdy = 1'b1;
        sys_rst = 1'b1;
        wait_cnt(32'd1, 30, "cnt_after_reset");
        repeat (3) step();
        chk(exp_data.size() == 0 && exp_addr.size() == 0 && !err_o && !busy_o, "drained",
            256'({exp_data.size(), exp_addr.size(), err_o, busy_o}), 256'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ddr_wr_cmd_sched.md
Name: ddr_wr_cmd_sched

Overview:
- Write-side command scheduler in the ddr_clk domain.
- Drains the arbitrated write address FIFO (30-bit entries) and write data FIFO (256-bit read port, two beats per 512-bit write) that the sys_clk-side arbiter fills.
- Sequences the DDR controller native write interface (data path, then command path) for each address/data pair, one BL8 write per address.
- Provides busy, completion and error status to the application.

Parameters:
ADDR_W, 27, width of app_addr; taken from wr_addr_fifo_data_out[ADDR_W-1:0].
DATA_W, 256, width of the data FIFO read port and app_wdf_data.
BEATS, 2, 256-bit beats per write command (fixed 2 in this release).

Ports:
ddr_clk  in  1  single clock for all logic.
sys_rst  in  1  asynchronous active-low reset.
phy_init_done_i  in  1  DDR calibration complete; already synchronous to ddr_clk.
wr_addr_fifo_rd_en  out  1  pop the address FIFO.
wr_addr_fifo_data_out  in  30  address FIFO head, valid one cycle after rd_en.
wr_addr_fifo_valid  in  1  address FIFO read-data valid.
wr_addr_fifo_empty  in  1  address FIFO empty.
wr_ddr_fifo_rd_en  out  1  pop the data FIFO.
wr_ddr_fifo_data_out  in  DATA_W  data FIFO head, valid one cycle after rd_en.
wr_ddr_fifo_valid  in  1  data FIFO read-data valid.
wr_ddr_fifo_rd_count  in  9  data FIFO occupancy, in DATA_W words.
app_en  out  1  command strobe.
app_cmd  out  3  command; always 3'b000 (write).
app_addr  out  ADDR_W  command address.
app_rdy  in  1  controller accepts command this cycle when app_en=1.
app_wdf_wren  out  1  write data strobe.
app_wdf_data  out  DATA_W  write data.
app_wdf_end  out  1  last beat of burst.
app_wdf_mask  out  DATA_W/8  byte mask; always 0.
app_wdf_rdy  in  1  controller accepts data this cycle when app_wdf_wren=1.
busy_o  out  1  1 in any state other than IDLE.
wr_done_o  out  1  one-cycle pulse when the command is accepted.
wr_cnt_o  out  32  count of completed write commands; wraps 0xFFFFFFFF->0.
err_o  out  1  sticky protocol error.

Behaviour:
- Reset (sys_rst=0, asynchronous): state=IDLE; all outputs 0; internal address/beat registers 0; wr_cnt_o=0; err_o=0.
- A reset asserted mid-burst aborts the burst. No partial command is reissued after release.
- States: IDLE, POP, CAP0, CAP1, WDF0, WDF1, CMD.
- IDLE: advance to POP when phy_init_done_i=1 AND wr_addr_fifo_empty=0 AND wr_ddr_fifo_rd_count>=BEATS. Otherwise stay.
- POP: wr_addr_fifo_rd_en=1 and wr_ddr_fifo_rd_en=1 for exactly this cycle. Go to CAP0.
- CAP0:
  - Requires wr_addr_fifo_valid=1 and wr_ddr_fifo_valid=1.
  - Latch address[ADDR_W-1:0] and beat0.
  - Assert wr_ddr_fifo_rd_en=1 for the second beat. Go to CAP1.
  - If either valid is 0: set err_o, rd_en stays 0, go to IDLE.
- CAP1: requires wr_ddr_fifo_valid=1. Latch beat1 and go to WDF0. If valid=0: set err_o, go to IDLE.
- WDF0: app_wdf_wren=1, app_wdf_data=beat0, app_wdf_end=0. Hold until app_wdf_rdy=1, then go to WDF1.
- WDF1: app_wdf_wren=1, app_wdf_data=beat1, app_wdf_end=1. Hold until app_wdf_rdy=1, then go to CMD.
- CMD: app_en=1, app_cmd=000, app_addr=latched address. Hold until app_rdy=1. On that cycle: wr_done_o=1, wr_cnt_o+1, next state IDLE.
- app_* outputs are decoded from registered state and data registers. All are stable while stalled (rdy=0).
- Minimum throughput: 7 cycles per write with rdy held high. Earliest next POP is 1 cycle after returning to IDLE.
- phy_init_done_i deasserting mid-burst does not abort the burst; it only blocks the next IDLE->POP.
- The rd_count threshold guarantees both beats are present. The address FIFO is never popped without its data.
- err_o clears only on reset.

Test Plan:
- Reset then phy_init_done_i=0 with FIFOs non-empty -> no rd_en ever asserted; busy_o=0.
- One entry: addr 0x0000_1040, beats A/B, rdy held high -> rd_en pulses at POP and CAP0; wren with data A then B (end=1 on B); app_en with app_addr=0x1040 in cycle 7; wr_done_o pulse; wr_cnt_o=1.
- app_wdf_rdy low 5 cycles in WDF1, then app_rdy low 3 cycles in CMD -> data/end/addr held stable; exactly one wren-accept per beat and one command accept.
- rd_count=1 with address FIFO non-empty -> stays IDLE; count raised to 2 -> proceeds normally.
- wr_ddr_fifo_valid forced 0 in CAP1 -> err_o=1 sticky; return to IDLE; no app_wdf_wren or app_en issued.
- sys_rst pulsed low during WDF1 stall -> all outputs 0 immediately; after release, the next queued entry is processed from POP.
